// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared widths, defaults and divisor arithmetic for the tick generator
package tick_gen_pkg;
  localparam int MIN_DIV_DEF = 2;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [63:0] default_div(input logic [63:0] hz, input logic [63:0] rate);
    return hz / rate;
  endfunction
  function automatic logic [63:0] clamp_div(input logic [63:0] d, input logic [63:0] min_div);
    return (d < min_div) ? min_div : d;
  endfunction
  function automatic logic [63:0] accel_div(input logic [63:0] base, input int shift, input logic [63:0] min_div);
    return clamp_div(base - (base >> shift), min_div);
  endfunction
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divider channel with shadowed divisor reload and accelerate
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int DIV_W = 32,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(10),
  parameter int MIN_DIV = MIN_DIV_DEF,
  parameter int ACCEL_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             acc,
  output logic             tick,
  output logic             square,
  output logic             shadow_full
);
  logic [DIV_W-1:0] cnt, active_div, shadow, base, nxt_shadow;
  logic wrap, load;
  always_comb begin
    wrap = en && cnt == active_div - DIV_W'(1);
    load = shadow_full && (!en || wrap);
    base = shadow_full ? shadow : active_div;
    nxt_shadow = wr ? DIV_W'(clamp_div(64'(wr_div), 64'(MIN_DIV)))
                    : DIV_W'(accel_div(64'(base), ACCEL_SHIFT, 64'(MIN_DIV)));
  end
  // a new shadow write in the wrap cycle survives for the next wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      active_div <= DEFAULT_DIV;
      shadow <= '0;
      shadow_full <= 1'b0;
      tick <= 1'b0;
      square <= 1'b0;
    end else begin
      cnt <= (en && !wrap) ? cnt + DIV_W'(1) : '0;
      tick <= wrap;
      if (wrap) square <= ~square;
      if (load) active_div <= shadow;
      if (wr || acc) begin
        shadow <= nxt_shadow;
        shadow_full <= 1'b1;
      end else if (load) shadow_full <= 1'b0;
    end
  end
endmodule

// File: rtl/tick_generator.sv
// tick_generator: multi-channel tick/square generator with runtime divisor config and accelerate
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int NUM_CH = 4,
  parameter int DIV_W = 32,
  parameter int DEFAULT_RATE = 1,
  parameter int MIN_DIV = MIN_DIV_DEF,
  parameter int ACCEL_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [NUM_CH-1:0]           accel,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           square
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(default_div(64'(CLK_HZ), 64'(DEFAULT_RATE)));
  logic [NUM_CH-1:0] full, wr, acc;
  logic [(1<<CH_W)-1:0] full_ext;
  logic xfer;
  // unused channel codes read as empty, so out-of-range writes are accepted and dropped
  always_comb begin
    full_ext = '0;
    full_ext[NUM_CH-1:0] = full;
    cfg_ready = !full_ext[cfg_ch];
    xfer = cfg_valid && cfg_ready;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = xfer && cfg_ch == CH_W'(i);
    assign acc[i] = accel[i] && !wr[i];
    tick_channel #(
      .DIV_W(DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV),
      .MIN_DIV(MIN_DIV),
      .ACCEL_SHIFT(ACCEL_SHIFT)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(en[i]),
      .wr(wr[i]),
      .wr_div(cfg_div),
      .acc(acc[i]),
      .tick(tick[i]),
      .square(square[i]),
      .shadow_full(full[i])
    );
  end
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed scenarios with a tick-event scoreboard for tick_generator
module tb_tick_generator;
  typedef struct {int cyc; int ch;} ev_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] en = '0, accel = '0, tick, square;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [2:0] cfg_ch = '0;
  logic [31:0] cfg_div = '0;
  int e = 0, compared = 0, mismatched = 0;
  ev_t sb[$];

  tick_generator #(
    .CLK_HZ(100), .NUM_CH(5), .DIV_W(32), .DEFAULT_RATE(10), .MIN_DIV(2), .ACCEL_SHIFT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .accel(accel), .tick(tick), .square(square)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic push(input int c, input logic [4:0] mask);
    for (int i = 0; i < 5; i++) if (mask[i]) sb.push_back('{c, i});
  endtask

  task automatic watch(input int n, input logic [4:0] mask);
    ev_t ev;
    for (int k = 0; k < n; k++) begin
      cyc();
      for (int c = 0; c < 5; c++) if (mask[c] && tick[c]) begin
        if (sb.size() == 0) chk("tick_extra", 32'(tick[c]), 0);
        else begin
          ev = sb.pop_front();
          chk("tick_cyc", e, ev.cyc);
          chk("tick_ch", c, ev.ch);
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    e = 0;
  endtask

  initial begin
    // reset state
    en = '0;
    do_reset();
    rst_n = 1'b0;
    cyc();
    chk("rst_tick", tick, 0);
    chk("rst_square", square, 0);
    chk("rst_ready", cfg_ready, 1);
    // free-running, all channels aligned
    en = '1;
    do_reset();
    push(10, '1); push(20, '1); push(30, '1);
    watch(10, '1); chk("sq_10", square, 5'b11111);
    watch(10, '1); chk("sq_20", square, 5'b00000);
    watch(10, '1); chk("sq_30", square, 5'b11111);
    drain("free_drain");
    // ch1 div=4 written at cycle 3
    do_reset();
    push(10, 5'b00010); push(14, 5'b00010); push(18, 5'b00010);
    watch(2, 5'b00010);
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd4;
    #1 chk("wr1_ready_pre", cfg_ready, 1);
    watch(1, 5'b00010);
    cfg_valid = 1'b0;
    #1 chk("wr1_ready_low", cfg_ready, 0);
    watch(6, 5'b00010); chk("wr1_ready_e9", cfg_ready, 0);
    watch(1, 5'b00010); chk("wr1_ready_e10", cfg_ready, 1);
    watch(8, 5'b00010);
    drain("wr1_drain");
    // ch2 div=0 clamps to 2
    do_reset();
    push(10, 5'b00100); push(12, 5'b00100); push(14, 5'b00100); push(16, 5'b00100);
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd0;
    watch(1, 5'b00100);
    cfg_valid = 1'b0;
    watch(9, 5'b00100); chk("clamp_sq10", 32'(square[2]), 1);
    watch(2, 5'b00100); chk("clamp_sq12", 32'(square[2]), 0);
    watch(2, 5'b00100); chk("clamp_sq14", 32'(square[2]), 1);
    watch(2, 5'b00100);
    drain("clamp_drain");
    // accel[3] three times: 10 -> 8 -> 6 -> 5
    do_reset();
    push(10, 5'b01000); push(15, 5'b01000); push(20, 5'b01000);
    watch(2, 5'b01000);
    accel = 5'b01000;
    watch(3, 5'b01000);
    accel = '0;
    cfg_ch = 3'd3;
    #1 chk("accel_ready", cfg_ready, 0);
    watch(15, 5'b01000);
    drain("accel_drain");
    // config beats accel on the same channel
    do_reset();
    push(10, 5'b00001); push(17, 5'b00001); push(24, 5'b00001);
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 32'd7; accel = 5'b00001;
    watch(1, 5'b00001);
    cfg_valid = 1'b0; accel = '0;
    watch(23, 5'b00001);
    drain("prio_drain");
    // out-of-range channel accepted and dropped
    do_reset();
    push(10, '1); push(20, '1);
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 32'd3;
    #1 chk("oor_ready", cfg_ready, 1);
    watch(1, '1);
    cfg_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cfg_ch = 3'(c);
      #1 chk("oor_ch_ready", cfg_ready, 1);
    end
    watch(19, '1);
    drain("oor_drain");
    // en[0] dropped for 3 cycles mid-count
    do_reset();
    push(10, 5'b00001); push(27, 5'b00001); push(37, 5'b00001);
    watch(14, 5'b00001);
    en[0] = 1'b0;
    watch(3, 5'b00001);
    chk("dis_sq_hold", 32'(square[0]), 1);
    chk("dis_tick", 32'(tick[0]), 0);
    en[0] = 1'b1;
    watch(10, 5'b00001); chk("reen_sq", 32'(square[0]), 0);
    watch(10, 5'b00001);
    drain("en_drain");
    // reset mid-period drops pending shadow
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd4;
    watch(1, 5'b00010);
    cfg_valid = 1'b0;
    watch(4, 5'b00010);
    #1 chk("pend_ready", cfg_ready, 0);
    do_reset();
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_square", square, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    push(10, 5'b00010); push(20, 5'b00010);
    watch(20, 5'b00010);
    drain("rst_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
